// File: rtl/election_controller.sv
// Election controller: registration, voting, then a one-candidate-per-cycle winner scan.
// Define ELECTION_TIE_FLAG_EN to add the Tie output.
module election_controller #(
    parameter int ID_WIDTH       = 6,
    parameter int NUM_CANDIDATES = 4,
    parameter int CAND_WIDTH     = 2,
    parameter int BOX_WIDTH      = 2,
    parameter int REG_CYCLES     = 100,
    parameter int VOTE_CYCLES    = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req,
    input  logic [1:0]            mode,
    input  logic [ID_WIDTH-1:0]   userID,
    input  logic [CAND_WIDTH-1:0] candidate,
    output logic [1:0]            phase,
    output logic [BOX_WIDTH-1:0]  ballotBoxId,
    output logic [ID_WIDTH:0]     numberOfRegisteredVoters,
    output logic [ID_WIDTH:0]     numberOfVotesCast,
    output logic [ID_WIDTH:0]     numberOfVotesWinner,
    output logic [CAND_WIDTH-1:0] WinnerId,
    output logic                  resultValid,
    output logic                  AlreadyRegistered,
    output logic                  AlreadyVoted,
    output logic                  NotRegistered,
    output logic                  VotingHasNotStarted,
    output logic                  RegistrationHasEnded,
    output logic                  InvalidCandidate
`ifdef ELECTION_TIE_FLAG_EN
    ,
    output logic                  Tie
`endif
);

    localparam int VOTERS = 2 ** ID_WIDTH;
    localparam int SLOTS  = 2 ** CAND_WIDTH;

    typedef enum logic [1:0] {
        PH_REG  = 2'd0,
        PH_VOTE = 2'd1,
        PH_SCAN = 2'd2,
        PH_DONE = 2'd3
    } phase_t;

    phase_t                state;
    phase_t                state_next;
    logic [31:0]           cnt;
    logic [31:0]           cnt_next;
    logic [VOTERS-1:0]     registered;
    logic [VOTERS-1:0]     voted;
    logic [ID_WIDTH:0]     tally [SLOTS];
    logic [ID_WIDTH:0]     best_votes;
    logic [CAND_WIDTH-1:0] best_id;
    logic [CAND_WIDTH-1:0] scan_id;
    logic                  do_reg;
    logic                  do_vote;
    logic                  bad_cand;

    assign do_reg   = req && (mode == 2'd0);
    assign do_vote  = req && (mode == 2'd1);
    assign bad_cand = 32'(candidate) >= 32'(NUM_CANDIDATES);
    // Within SCAN the phase counter doubles as the candidate index.
    assign scan_id  = cnt[CAND_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= PH_REG;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 32'd1;
        unique case (state)
            PH_REG: if (cnt == 32'(REG_CYCLES - 1)) begin
                state_next = PH_VOTE;
                cnt_next   = '0;
            end
            PH_VOTE: if (cnt == 32'(VOTE_CYCLES - 1)) begin
                state_next = PH_SCAN;
                cnt_next   = '0;
            end
            PH_SCAN: if (cnt == 32'(NUM_CANDIDATES - 1)) begin
                state_next = PH_DONE;
                cnt_next   = '0;
            end
            PH_DONE: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            registered               <= '0;
            voted                    <= '0;
            for (int i = 0; i < SLOTS; i++) tally[i] <= '0;
            numberOfRegisteredVoters <= '0;
            numberOfVotesCast        <= '0;
            ballotBoxId              <= '0;
            best_votes               <= '0;
            best_id                  <= '0;
            AlreadyRegistered        <= 1'b0;
            AlreadyVoted             <= 1'b0;
            NotRegistered            <= 1'b0;
            VotingHasNotStarted      <= 1'b0;
            RegistrationHasEnded     <= 1'b0;
            InvalidCandidate         <= 1'b0;
        end else begin
            AlreadyRegistered    <= 1'b0;
            AlreadyVoted         <= 1'b0;
            NotRegistered        <= 1'b0;
            VotingHasNotStarted  <= 1'b0;
            RegistrationHasEnded <= 1'b0;
            InvalidCandidate     <= 1'b0;

            if (req) ballotBoxId <= userID[ID_WIDTH-1 -: BOX_WIDTH];

            if (do_reg && state == PH_REG) begin
                if (registered[userID]) begin
                    AlreadyRegistered <= 1'b1;
                end else begin
                    registered[userID] <= 1'b1;
                    if (~&numberOfRegisteredVoters)
                        numberOfRegisteredVoters <= numberOfRegisteredVoters + 1'b1;
                end
            end

            if (do_reg && state == PH_VOTE) RegistrationHasEnded <= 1'b1;
            if (do_vote && state == PH_REG) VotingHasNotStarted <= 1'b1;

            if (do_vote && state == PH_VOTE) begin
                if (!registered[userID]) begin
                    NotRegistered <= 1'b1;
                end else if (voted[userID]) begin
                    AlreadyVoted <= 1'b1;
                end else if (bad_cand) begin
                    InvalidCandidate <= 1'b1;
                end else begin
                    voted[userID] <= 1'b1;
                    if (~&tally[candidate])
                        tally[candidate] <= tally[candidate] + 1'b1;
                    if (~&numberOfVotesCast)
                        numberOfVotesCast <= numberOfVotesCast + 1'b1;
                end
            end

            // Strict compare keeps the lowest index on ties.
            if (state == PH_SCAN && tally[scan_id] > best_votes) begin
                best_votes <= tally[scan_id];
                best_id    <= scan_id;
            end
        end
    end

`ifdef ELECTION_TIE_FLAG_EN
    logic tie_seen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tie_seen <= 1'b0;
        end else if (state == PH_SCAN) begin
            if (tally[scan_id] > best_votes)
                tie_seen <= 1'b0;
            else if (tally[scan_id] == best_votes && best_votes != '0)
                tie_seen <= 1'b1;
        end
    end

    assign Tie = (state == PH_DONE) && tie_seen;
`endif

    assign phase               = state;
    assign resultValid         = (state == PH_DONE);
    assign WinnerId            = resultValid ? best_id : '0;
    assign numberOfVotesWinner = resultValid ? best_votes : '0;

endmodule

// File: tb/tb_election_controller.sv
// Randomised bench for election_controller against a cycle-numbered reference model.
// Honours ELECTION_TIE_FLAG_EN when the design is built with it.
module tb_election_controller;

    localparam int IDW = 6;
    localparam int NC  = 3;
    localparam int CW  = 2;
    localparam int BW  = 2;
    localparam int RC  = 8;
    localparam int VC  = 8;
    localparam int MAXC = 127;

    logic           CLK = 1'b0;
    logic           RST;
    logic           req;
    logic [1:0]     mode;
    logic [IDW-1:0] userID;
    logic [CW-1:0]  candidate;
    logic [1:0]     phase;
    logic [BW-1:0]  ballotBoxId;
    logic [IDW:0]   numberOfRegisteredVoters;
    logic [IDW:0]   numberOfVotesCast;
    logic [IDW:0]   numberOfVotesWinner;
    logic [CW-1:0]  WinnerId;
    logic           resultValid;
    logic           AlreadyRegistered;
    logic           AlreadyVoted;
    logic           NotRegistered;
    logic           VotingHasNotStarted;
    logic           RegistrationHasEnded;
    logic           InvalidCandidate;
`ifdef ELECTION_TIE_FLAG_EN
    logic           Tie;
`endif

    election_controller #(
        .ID_WIDTH(IDW), .NUM_CANDIDATES(NC), .CAND_WIDTH(CW),
        .BOX_WIDTH(BW), .REG_CYCLES(RC), .VOTE_CYCLES(VC)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .mode(mode),
        .userID(userID), .candidate(candidate), .phase(phase),
        .ballotBoxId(ballotBoxId),
        .numberOfRegisteredVoters(numberOfRegisteredVoters),
        .numberOfVotesCast(numberOfVotesCast),
        .numberOfVotesWinner(numberOfVotesWinner),
        .WinnerId(WinnerId), .resultValid(resultValid),
        .AlreadyRegistered(AlreadyRegistered),
        .AlreadyVoted(AlreadyVoted),
        .NotRegistered(NotRegistered),
        .VotingHasNotStarted(VotingHasNotStarted),
        .RegistrationHasEnded(RegistrationHasEnded),
        .InvalidCandidate(InvalidCandidate)
`ifdef ELECTION_TIE_FLAG_EN
        ,
        .Tie(Tie)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference state; cyc is the 1-based cycle number since reset release.
    bit reg_m   [64];
    bit voted_m [64];
    int tally_m [NC];
    int nreg_m;
    int ncast_m;
    int ballot_m;
    int flags_m;
    int cyc;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int phase_of(input int c);
        if (c <= RC) return 0;
        if (c <= RC + VC) return 1;
        if (c <= RC + VC + NC) return 2;
        return 3;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic check_all();
        int ph;
        int win;
        int wv;
        int ties;
        ph   = phase_of(cyc);
        win  = 0;
        wv   = 0;
        ties = 0;
        if (ph == 3) begin
            for (int k = 0; k < NC; k++)
                if (tally_m[k] > wv) begin
                    wv  = tally_m[k];
                    win = k;
                end
            for (int k = 0; k < NC; k++)
                if (tally_m[k] == wv) ties++;
        end
        check("phase", int'(phase), ph);
        check("ballot", int'(ballotBoxId), ballot_m);
        check("nreg", int'(numberOfRegisteredVoters), nreg_m);
        check("ncast", int'(numberOfVotesCast), ncast_m);
        check("winner", int'(WinnerId), win);
        check("winvotes", int'(numberOfVotesWinner), wv);
        check("valid", int'(resultValid), int'(ph == 3));
        check("flags", int'({AlreadyRegistered, AlreadyVoted, NotRegistered,
                              VotingHasNotStarted, RegistrationHasEnded,
                              InvalidCandidate}), flags_m);
`ifdef ELECTION_TIE_FLAG_EN
        check("tie", int'(Tie), int'(ph == 3 && wv > 0 && ties >= 2));
`endif
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 64; i++) begin
            reg_m[i]   = 1'b0;
            voted_m[i] = 1'b0;
        end
        for (int k = 0; k < NC; k++) tally_m[k] = 0;
        nreg_m   = 0;
        ncast_m  = 0;
        ballot_m = 0;
        flags_m  = 0;
        cyc      = 1;
        check_all();
    endtask

    // Request is judged by the phase of the cycle in which it is sampled.
    task automatic model(input bit r, input int m, input int id, input int c);
        int ph;
        ph      = phase_of(cyc);
        flags_m = 0;
        if (r) begin
            ballot_m = id >> (IDW - BW);
            if (m == 0 && ph == 0) begin
                if (reg_m[id]) flags_m = 32;
                else begin
                    reg_m[id] = 1'b1;
                    nreg_m    = sat_inc(nreg_m);
                end
            end else if (m == 0 && ph == 1) begin
                flags_m = 2;
            end else if (m == 1 && ph == 0) begin
                flags_m = 4;
            end else if (m == 1 && ph == 1) begin
                if (!reg_m[id]) flags_m = 8;
                else if (voted_m[id]) flags_m = 16;
                else if (c >= NC) flags_m = 1;
                else begin
                    voted_m[id] = 1'b1;
                    tally_m[c]  = sat_inc(tally_m[c]);
                    ncast_m     = sat_inc(ncast_m);
                end
            end
        end
    endtask

    task automatic step(input bit r, input int m, input int id, input int c);
        req       = r;
        mode      = m[1:0];
        userID    = id[IDW-1:0];
        candidate = c[CW-1:0];
        @(posedge CLK);
        #1;
        model(r, m, id, c);
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, (i % 2 == 0) ? 1 : 3, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        RST       = 1'b1;
        req       = 1'b0;
        mode      = 2'd0;
        userID    = '0;
        candidate = '0;

        // Election 1: registration rules, wrong-phase requests, tied result.
        do_reset();
        step(1, 0, 5, 0);
        step(1, 0, 5, 0);
        step(1, 0, 63, 0);
        step(1, 1, 5, 1);
        step(1, 0, 10, 0);
        step(1, 0, 20, 0);
        step(1, 2, 33, 0);
        step(1, 0, 30, 0);
        step(1, 0, 40, 0);
        step(1, 1, 5, 3);
        step(1, 1, 5, 1);
        step(1, 1, 5, 1);
        step(1, 1, 63, 1);
        step(1, 1, 10, 0);
        step(1, 1, 20, 0);
        step(1, 1, 30, 2);
        step(1, 0, 41, 0);
        idle(6);
        step(1, 1, 20, 1);
        idle(2);

        // Election 2: reset in the middle of voting.
        do_reset();
        step(1, 0, 5, 0);
        step(1, 0, 9, 0);
        idle(7);
        step(1, 1, 5, 0);
        idle(1);
        do_reset();

        // Election 3: only rejected votes, so the result is empty.
        step(1, 0, 5, 0);
        idle(8);
        step(1, 1, 7, 0);
        idle(12);

        // Randomised elections over a small ID pool to force collisions.
        for (int e = 0; e < 8; e++) begin
            do_reset();
            for (int c = 0; c < 26; c++) begin
                if ($urandom_range(0, 59) == 0)
                    do_reset();
                else
                    step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 11)), int'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
